// File: rtl/ldm_stm_sequencer.sv
// Load/store-multiple sequencer: walks a register list, issuing one word
// access per register, then an optional base-register writeback.
module ldm_stm_sequencer #(
  parameter int ADDR_W = 32,
  parameter int NREGS  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       is_load,
  input  logic                       p_bit,
  input  logic                       u_bit,
  input  logic                       w_bit,
  input  logic [$clog2(NREGS)-1:0]   rn,
  input  logic [ADDR_W-1:0]          base,
  input  logic [NREGS-1:0]           reglist,
  output logic [$clog2(NREGS)-1:0]   rf_ra,
  input  logic [31:0]                rf_rd,
  output logic [$clog2(NREGS)-1:0]   rf_wa,
  output logic [31:0]                rf_wd,
  output logic                       rf_we,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [31:0]                mem_wd,
  input  logic [31:0]                mem_rd,
  input  logic                       mem_ready,
  output logic                       busy,
  output logic                       done,
  output logic                       pc_loaded
);

  localparam int IW = $clog2(NREGS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] XFER = 2'd1;
  localparam logic [1:0] WB   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [NREGS-1:0]  list_q, list_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] fbase_q, fbase_d;
  logic              load_q, load_d;
  logic              w_q, w_d;
  logic              rnin_q, rnin_d;
  logic [IW-1:0]     rn_q, rn_d;

  logic [IW:0]       cnt;
  logic [ADDR_W-1:0] off4;
  logic [ADDR_W-1:0] saddr;
  logic [IW-1:0]     cur;
  logic              found;
  logic [NREGS-1:0]  list_rest;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < NREGS; i++) begin
      cnt = cnt + {{IW{1'b0}}, reglist[i]};
    end
  end

  assign off4 = ADDR_W'({cnt, 2'b00});

  always_comb begin
    unique case ({p_bit, u_bit})
      2'b01:   saddr = base;
      2'b11:   saddr = base + ADDR_W'(4);
      2'b00:   saddr = base - off4 + ADDR_W'(4);
      default: saddr = base - off4;
    endcase
  end

  always_comb begin
    cur   = '0;
    found = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (list_q[i] && !found) begin
        cur   = IW'(i);
        found = 1'b1;
      end
    end
  end

  // Clearing the lowest set bit yields the list left after this transfer.
  assign list_rest = list_q & (list_q - NREGS'(1));

  always_comb begin
    state_d = state_q;
    list_d  = list_q;
    addr_d  = addr_q;
    fbase_d = fbase_q;
    load_d  = load_q;
    w_d     = w_q;
    rnin_d  = rnin_q;
    rn_d    = rn_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          list_d  = reglist;
          load_d  = is_load;
          w_d     = w_bit;
          rn_d    = rn;
          rnin_d  = reglist[rn];
          addr_d  = saddr;
          fbase_d = u_bit ? base + off4 : base - off4;
          state_d = (cnt == '0) ? WB : XFER;
        end
      end
      XFER: begin
        if (mem_ready) begin
          list_d = list_rest;
          addr_d = addr_q + ADDR_W'(4);
          if (list_rest == '0) state_d = WB;
        end
      end
      WB:      state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      list_q  <= '0;
      addr_q  <= '0;
      fbase_q <= '0;
      load_q  <= 1'b0;
      w_q     <= 1'b0;
      rnin_q  <= 1'b0;
      rn_q    <= '0;
    end else begin
      state_q <= state_d;
      list_q  <= list_d;
      addr_q  <= addr_d;
      fbase_q <= fbase_d;
      load_q  <= load_d;
      w_q     <= w_d;
      rnin_q  <= rnin_d;
      rn_q    <= rn_d;
    end
  end

  logic xfer, st, ld_we, wb_we;

  assign xfer  = (state_q == XFER);
  assign st    = xfer && !load_q;
  assign ld_we = xfer && load_q && mem_ready;
  // A loaded Rn takes precedence over the writeback value.
  assign wb_we = (state_q == WB) && w_q && !(load_q && rnin_q);

  assign mem_req   = xfer;
  assign mem_we    = st;
  assign mem_addr  = xfer ? addr_q : '0;
  assign rf_ra     = st ? cur : '0;
  assign mem_wd    = st ? rf_rd : '0;
  assign rf_we     = ld_we || wb_we;
  assign rf_wa     = ld_we ? cur : (wb_we ? rn_q : '0);
  assign rf_wd     = ld_we ? mem_rd : (wb_we ? 32'(fbase_q) : '0);
  assign pc_loaded = ld_we && (cur == '1);
  assign busy      = xfer || (state_q == WB);
  assign done      = (state_q == DONE);

endmodule
